// File: rtl/me_sad_select.sv
// Minimum-SAD selector: sums per-row SADs into candidate totals and keeps the best motion vector of a search.
// Optional macro ME_ZERO_BIAS_EN: equal-SAD ties go to the candidate with the smaller |dx|+|dy|.
module me_sad_select #(
  parameter int BLK_ROWS = 8,
  parameter int ROW_W    = 11,
  parameter int MV_W     = 5,
  parameter int CNT_W    = 10
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cand_valid,
  output logic                                 cand_ready,
  input  logic [ROW_W-1:0]                     cand_row_sad,
  input  logic signed [MV_W-1:0]               cand_dx,
  input  logic signed [MV_W-1:0]               cand_dy,
  input  logic                                 search_last,
  output logic                                 mv_valid,
  input  logic                                 mv_ready,
  output logic signed [MV_W-1:0]               mv_dx,
  output logic signed [MV_W-1:0]               mv_dy,
  output logic [ROW_W+$clog2(BLK_ROWS)-1:0]    mv_sad,
  output logic [CNT_W-1:0]                     mv_cands
);

  localparam int ROW_BITS = $clog2(BLK_ROWS);
  localparam int SAD_W    = ROW_W + ROW_BITS;
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(BLK_ROWS - 1);

  // state   | meaning
  // ST_ACC  | accepting row beats, tracking the best candidate
  // ST_HOLD | result presented on mv_*, waiting for the consumer
  typedef enum logic {ST_ACC, ST_HOLD} state_t;
  state_t state, state_next;

  logic [SAD_W-1:0]       acc, best_sad, total;
  logic [ROW_BITS-1:0]    row;
  logic [CNT_W-1:0]       cands;
  logic signed [MV_W-1:0] best_dx, best_dy;
  logic                   have_best;
  logic                   beat, cand_done, take, finish, release_mv;

`ifdef ME_ZERO_BIAS_EN
  function automatic logic [MV_W:0] mag(input logic signed [MV_W-1:0] dx,
                                        input logic signed [MV_W-1:0] dy);
    logic [MV_W-1:0] ax, ay;
    ax = dx[MV_W-1] ? $unsigned(-dx) : $unsigned(dx);
    ay = dy[MV_W-1] ? $unsigned(-dy) : $unsigned(dy);
    return {1'b0, ax} + {1'b0, ay};
  endfunction
`endif

  always_comb begin
    state_next = state;
    beat       = 1'b0;
    cand_done  = 1'b0;
    take       = 1'b0;
    finish     = 1'b0;
    release_mv = 1'b0;
    total      = acc + SAD_W'(cand_row_sad);
    case (state)
      ST_ACC: begin
        beat      = cand_valid & cand_ready;
        cand_done = beat && (row == LAST_ROW);
        if (cand_done) begin
          take = !have_best || (total < best_sad);
`ifdef ME_ZERO_BIAS_EN
          if (have_best && (total == best_sad) &&
              (mag(cand_dx, cand_dy) < mag(best_dx, best_dy)))
            take = 1'b1;
`endif
          if (search_last) begin
            finish     = 1'b1;
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        release_mv = mv_valid & mv_ready;
        if (release_mv) state_next = ST_ACC;
      end
      default: state_next = ST_ACC;
    endcase
  end

  // cand_ready is a registered image of the state so it stays low through reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_ACC;
      cand_ready <= 1'b0;
    end else begin
      state      <= state_next;
      cand_ready <= (state_next == ST_ACC);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc       <= '0;
      row       <= '0;
      cands     <= '0;
      best_sad  <= '0;
      best_dx   <= '0;
      best_dy   <= '0;
      have_best <= 1'b0;
      mv_valid  <= 1'b0;
      mv_dx     <= '0;
      mv_dy     <= '0;
      mv_sad    <= '0;
      mv_cands  <= '0;
    end else begin
      if (beat) begin
        if (cand_done) begin
          acc   <= '0;
          row   <= '0;
          cands <= cands + CNT_W'(1);
          if (take) begin
            best_sad  <= total;
            best_dx   <= cand_dx;
            best_dy   <= cand_dy;
            have_best <= 1'b1;
          end
          if (finish) begin
            mv_valid <= 1'b1;
            mv_sad   <= take ? total   : best_sad;
            mv_dx    <= take ? cand_dx : best_dx;
            mv_dy    <= take ? cand_dy : best_dy;
            mv_cands <= cands + CNT_W'(1);
          end
        end else begin
          acc <= total;
          row <= row + ROW_BITS'(1);
        end
      end
      if (release_mv) begin
        mv_valid  <= 1'b0;
        acc       <= '0;
        row       <= '0;
        cands     <= '0;
        best_sad  <= '0;
        best_dx   <= '0;
        best_dy   <= '0;
        have_best <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_me_sad_select.sv
// Bench for me_sad_select: directed test-plan cases plus randomized searches against a candidate-list model.
`timescale 1ns/1ps
module tb_me_sad_select;
  localparam int BLK_ROWS = 8;
  localparam int ROW_W    = 11;
  localparam int MV_W     = 5;
  localparam int CNT_W    = 10;
  localparam int SAD_W    = 14;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   cand_valid = 1'b0;
  logic                   cand_ready;
  logic [ROW_W-1:0]       cand_row_sad = '0;
  logic signed [MV_W-1:0] cand_dx = '0;
  logic signed [MV_W-1:0] cand_dy = '0;
  logic                   search_last = 1'b0;
  logic                   mv_valid;
  logic                   mv_ready = 1'b0;
  logic signed [MV_W-1:0] mv_dx, mv_dy;
  logic [SAD_W-1:0]       mv_sad;
  logic [CNT_W-1:0]       mv_cands;

  always #5 clk = ~clk;

  me_sad_select #(.BLK_ROWS(BLK_ROWS), .ROW_W(ROW_W), .MV_W(MV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_row_sad(cand_row_sad),
    .cand_dx(cand_dx), .cand_dy(cand_dy), .search_last(search_last),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_dx(mv_dx), .mv_dy(mv_dy),
    .mv_sad(mv_sad), .mv_cands(mv_cands)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference model: collects candidate totals of the current search, picks the winner at search end.
  bit                     started = 0;
  bit                     exp_ready = 0;
  bit                     exp_valid = 0;
  logic signed [MV_W-1:0] exp_dx = '0, exp_dy = '0;
  int                     exp_sad = 0, exp_cands = 0;
  int                     cur_sum = 0, rows_done = 0;
  int                     q_tot[$], q_dx[$], q_dy[$];

  function automatic int mag(input int dx, input int dy);
    return (dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      started = 1;
      exp_ready = 0; exp_valid = 0;
      exp_dx = '0; exp_dy = '0; exp_sad = 0; exp_cands = 0;
      cur_sum = 0; rows_done = 0;
      q_tot.delete(); q_dx.delete(); q_dy.delete();
    end else if (exp_valid) begin
      if (mv_ready) begin
        exp_valid = 0;
        exp_ready = 1;
      end
    end else begin
      if (exp_ready && cand_valid) begin
        cur_sum += int'(cand_row_sad);
        rows_done++;
        if (rows_done == BLK_ROWS) begin
          q_tot.push_back(cur_sum);
          q_dx.push_back(int'(cand_dx));
          q_dy.push_back(int'(cand_dy));
          cur_sum = 0;
          rows_done = 0;
          if (search_last) begin
            int w;
            w = 0;
            for (int i = 1; i < q_tot.size(); i++) begin
              if (q_tot[i] < q_tot[w]) w = i;
`ifdef ME_ZERO_BIAS_EN
              else if (q_tot[i] == q_tot[w] && mag(q_dx[i], q_dy[i]) < mag(q_dx[w], q_dy[w])) w = i;
`endif
            end
            exp_sad   = q_tot[w];
            exp_dx    = MV_W'(q_dx[w]);
            exp_dy    = MV_W'(q_dy[w]);
            exp_cands = q_tot.size() % (1 << CNT_W);
            exp_valid = 1;
            q_tot.delete(); q_dx.delete(); q_dy.delete();
          end
        end
      end
      exp_ready = !exp_valid;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cand_ready", cand_ready, exp_ready);
      chk("mv_valid", mv_valid, exp_valid);
      chk("mv_dx", mv_dx, exp_dx);
      chk("mv_dy", mv_dy, exp_dy);
      chk("mv_sad", mv_sad, exp_sad);
      chk("mv_cands", mv_cands, exp_cands);
    end
  end

  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) mv_ready = ($urandom_range(0, 3) != 0);
  end

  // Called and returns at posedge+1; holds the beat until the DUT accepts it.
  task automatic beat(input int row_sad, input int dx, input int dy, input bit last);
    int n;
    cand_valid   = 1'b1;
    cand_row_sad = ROW_W'(row_sad);
    cand_dx      = MV_W'(dx);
    cand_dy      = MV_W'(dy);
    search_last  = last;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cand_ready && n < 300);
    if (!cand_ready) timeout("beat_accept");
    @(posedge clk);
    #1;
    cand_valid  = 1'b0;
    search_last = 1'b0;
  endtask

  task automatic send_total(input int total, input int dx, input int dy, input bit last);
    for (int i = 0; i < BLK_ROWS; i++)
      beat(total / BLK_ROWS + (i == 0 ? total % BLK_ROWS : 0), dx, dy, last && (i == BLK_ROWS - 1));
  endtask

  task automatic expect_result(input string name, input int sad, input int dx, input int dy, input int nc);
    @(negedge clk);
    chk({name, "_valid"}, mv_valid, 1);
    chk({name, "_sad"}, mv_sad, sad);
    chk({name, "_dx"}, mv_dx, dx);
    chk({name, "_dy"}, mv_dy, dy);
    chk({name, "_cands"}, mv_cands, nc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cand_ready, 0);
    chk("rst_valid", mv_valid, 0);
    chk("rst_sad", mv_sad, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ready_first", cand_ready, 0);
    @(negedge clk);
    chk("rel_ready_second", cand_ready, 1);
    @(posedge clk); #1;

    mv_ready = 1'b1;
    for (int i = 0; i < BLK_ROWS; i++) beat(10, 3, -2, i == BLK_ROWS - 1);
    expect_result("single", 80, 3, -2, 1);

    send_total(200, 1, 1, 0);
    send_total(150, -4, 0, 0);
    send_total(300, 0, 5, 1);
    expect_result("three", 150, -4, 0, 3);

    send_total(100, 2, 2, 0);
    send_total(100, 0, 0, 1);
`ifdef ME_ZERO_BIAS_EN
    expect_result("tie", 100, 0, 0, 2);
`else
    expect_result("tie", 100, 2, 2, 2);
`endif

    mv_ready = 1'b0;
    send_total(120, 1, 2, 1);
    expect_result("bp", 120, 1, 2, 1);
    for (int i = 0; i < 5; i++) begin
      cand_valid = 1'b1; cand_row_sad = ROW_W'(99); search_last = 1'b1;
      @(negedge clk);
      chk("bp_ready", cand_ready, 0);
      chk("bp_sad", mv_sad, 120);
      chk("bp_valid", mv_valid, 1);
      @(posedge clk); #1;
    end
    cand_valid = 1'b0; search_last = 1'b0;
    mv_ready = 1'b1;
    send_total(64, -1, 3, 1);
    expect_result("after_bp", 64, -1, 3, 1);

    for (int i = 0; i < 3; i++) beat(500, 4, 4, 0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", mv_valid, 0);
    chk("midrst_ready", cand_ready, 0);
    chk("midrst_sad", mv_sad, 0);
    chk("midrst_cands", mv_cands, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < BLK_ROWS; i++) beat(7, 0, 1, i == BLK_ROWS - 1);
    expect_result("post_rst", 56, 0, 1, 1);

    for (int i = 0; i < BLK_ROWS; i++) beat(2040, -15, 15, i == BLK_ROWS - 1);
    expect_result("extreme", 16320, -15, 15, 1);

    rdy_mode = 1;
    for (int s = 0; s < 40; s++) begin
      int ncand;
      bit tie_mode;
      ncand = $urandom_range(1, 6);
      tie_mode = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < ncand; c++) begin
        int dx, dy;
        if (tie_mode) begin
          dx = $urandom_range(0, 2) - 1;
          dy = $urandom_range(0, 2) - 1;
        end else begin
          dx = $urandom_range(0, 30) - 15;
          dy = $urandom_range(0, 30) - 15;
        end
        for (int r = 0; r < BLK_ROWS; r++) begin
          bit last;
          int rs;
          rs = tie_mode ? $urandom_range(0, 1) : $urandom_range(0, 2040);
          last = (r == BLK_ROWS - 1) ? (c == ncand - 1) : ($urandom_range(0, 9) == 0);
          if ($urandom_range(0, 4) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          beat(rs, dx, dy, last);
        end
      end
    end
    rdy_mode = 0;
    mv_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/me_sad_select.md
# me_sad_select

Downstream stage of the motion-estimation engine. It accumulates the per-row SAD values that the engine streams out for each candidate displacement of an 8x8 current block against the reference window. It keeps the minimum-SAD candidate across a whole search and presents the winning motion vector, its SAD and the candidate count on a valid/ready output. The consumer is the MV writeback/entropy stage.

## Interface
- BLK_ROWS, 8, rows per candidate block; must be a power of two.
- ROW_W, 11, row SAD width (8 pixels x 255 max = 2040).
- MV_W, 5, signed width of dx/dy (search range r up to 15).
- CNT_W, 10, candidate counter width ((2*15+1)^2 = 961 max).
- SAD_W, derived, ROW_W + log2(BLK_ROWS) = 14; localparam, not overridable.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge clears all state.
- cand_valid  in  1  a row SAD beat is offered.
- cand_ready  out  1  block accepts a beat; a beat transfers when cand_valid & cand_ready.
- cand_row_sad  in  ROW_W  unsigned SAD of one block row.
- cand_dx, cand_dy  in  MV_W each  signed candidate displacement; sampled on the final row beat.
- search_last  in  1  marks the final candidate of the search; sampled on the final row beat only.
- mv_valid  out  1  result available.
- mv_ready  in  1  consumer accepts the result.
- mv_dx, mv_dy  out  MV_W each  winning displacement.
- mv_sad  out  SAD_W  winning SAD.
- mv_cands  out  CNT_W  candidates evaluated in this search.

## Operation
- There are two states: ACC and HOLD. Reset enters ACC.
- In ACC:
  - cand_ready = 1.
  - On each beat: acc += cand_row_sad, and row counter (0..BLK_ROWS-1) increments.
- On the beat where the row counter = BLK_ROWS-1 (candidate complete):
  - total = acc + cand_row_sad.
  - cands increments.
  - acc and the row counter return to 0.
  - If this is the first candidate of the search, or total < best_sad, then best_sad/best_dx/best_dy load total/cand_dx/cand_dy.
- On a tie, the earliest candidate wins (see Configuration).
- If search_last = 1 on that same beat, the final best values (including this candidate) load into the mv_* registers. mv_valid then rises and the state becomes HOLD.
- search_last on a non-final row is ignored.
- In HOLD:
  - cand_ready = 0; cand_valid is ignored.
  - mv_* are held stable until mv_valid & mv_ready.
  - On that handshake: mv_valid falls, the best/cands/acc registers clear, and the state returns to ACC.
- Arithmetic is unsigned and saturation is not needed: acc never exceeds 2^SAD_W - 1 by construction.
- cands wraps modulo 2^CNT_W; this is out of spec but must not hang the block.
- Reset mid-candidate or mid-HOLD discards everything; no partial result is ever emitted.

## Timing
- Reset values:
  - cand_ready = 0 while reset is low, then 1 from the first cycle after reset is released.
  - mv_valid = 0; mv_dx = mv_dy = 0; mv_sad = 0; mv_cands = 0.
- All outputs are registered. cand_ready is decoded from the state register only, with no combinational path from any input.
- Latency: mv_valid is asserted in the cycle after the clock edge that accepts the final beat with search_last.
- Handshake at edge k leaves mv_valid low and cand_ready high in cycle k+1. There is one bubble per search, so back-to-back searches lose exactly one cycle.
- mv_ready may be held high in advance. Deasserting mv_ready has no effect on the mv_* values.
- Throughput in ACC is one row beat per cycle with no stalls.

## Configuration
- ME_ZERO_BIAS_EN:
  - Defined: on a tie (total == best_sad), the candidate with the smaller |dx|+|dy| replaces the best. If that magnitude also ties, the earliest candidate is kept.
  - Undefined: the strict less-than compare keeps the earliest tied candidate.
- The macro changes no port, state or latency.

## Test plan
- Single candidate: 8 beats of row SAD 10, dx=3, dy=-2, search_last set on beat 8 -> mv_valid next cycle with mv_sad=80, mv_dx=3, mv_dy=-2, mv_cands=1.
- Three candidates with totals 200 at (1,1), 150 at (-4,0) and 300 at (0,5) -> mv_sad=150, mv_dx=-4, mv_dy=0, mv_cands=3.
- Tie: 100 at (2,2) then 100 at (0,0):
  - Without ME_ZERO_BIAS_EN -> result (2,2).
  - With ME_ZERO_BIAS_EN -> result (0,0).
- Backpressure: hold mv_ready=0 for 5 cycles after mv_valid while driving cand_valid=1:
  - During the stall -> mv_* stable and cand_ready=0, and no beats are absorbed.
  - After the handshake -> the next search sums correctly from zero.
- Reset mid-operation: reset low after 3 rows of 500 -> all outputs return to reset values. A following search of 8 rows of 7 gives mv_sad=56 and mv_cands=1.
- Extremes: 8 rows of 2040 at dx=-15, dy=15 -> mv_sad=16320, mv_dx=-15, mv_dy=15, with no overflow.
